// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the ADC sampler.
// Holds the FSM encoding and command nibble layout.
package adc_sampler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_e;

  localparam int CMD_LEN       = 4;
  localparam int CMD_START_POS = 3;
  localparam int CMD_SGL_POS   = 2;
  localparam int CMD_CH_POS    = 1;
  localparam int CMD_MSBF_POS  = 0;

  // Frame bit idx carries the command nibble MSB-first, zeros after it.
  function automatic logic cmd_bit(
    input logic [3:0]  cmd,
    input int unsigned idx
  );
    logic [3:0] sh;
    sh = cmd << idx;
    return (idx < CMD_LEN) ? sh[CMD_START_POS] : 1'b0;
  endfunction

endpackage

// File: rtl/adc_sampler_if.sv
// SPI pins and sample stream of the ADC sampler.
// master = sampler side, slave = ADC / consumer side.
interface adc_sampler_if #(
  parameter int DATA_WIDTH = 8
);

  logic                    adc_cs_n;
  logic                    adc_sclk;
  logic                    adc_mosi;
  logic                    adc_miso;
  logic [2*DATA_WIDTH-1:0] sample;
  logic                    sample_valid;
  logic                    overrun;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    output adc_mosi,
    input  adc_miso,
    output sample,
    output sample_valid,
    output overrun
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    input  adc_mosi,
    output adc_miso,
    input  sample,
    input  sample_valid,
    input  overrun
  );

endinterface

// File: rtl/adc_sampler_timer.sv
// Free-running conversion period counter.
// tick is high on the wrap cycle of the 0..SAMPLE_PERIOD-1 count.
module sample_timer #(
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW =
    (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// Periodic SPI ADC reader producing signed samples for the DFT stage.
// One frame per period tick; ticks arriving while busy set overrun.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         ADC_BITS      = 10,
  parameter int         FRAME_BITS    = 16,
  parameter int         CLK_DIV       = 4,
  parameter int         SAMPLE_PERIOD = 1000,
  parameter logic [3:0] CMD           = 4'b1101
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  adc_sampler_if.master bus
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int DB = $clog2(2 * CLK_DIV) + 1;
  localparam int BB = $clog2(FRAME_BITS) + 1;

  localparam logic [DB-1:0] DIV_LAST = DB'(CLK_DIV - 1);
  localparam logic [DB-1:0] PER_LAST = DB'(2 * CLK_DIV - 1);
  localparam logic [BB-1:0] BIT_LAST = BB'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [DB-1:0]         div_q, div_d;
  logic [BB-1:0]         bit_q, bit_d;
  logic [ADC_BITS-1:0]   shreg_q, shreg_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [SW-1:0]         sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  tick;

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Offset-binary to two's complement is an MSB flip.
  function automatic logic [SW-1:0] to_sample(
    input logic [ADC_BITS-1:0] code
  );
    logic signed [ADC_BITS-1:0] s;
    s = $signed({~code[ADC_BITS-1], code[ADC_BITS-2:0]});
    s = s >>> (ADC_BITS - DATA_WIDTH);
    return {{DATA_WIDTH{s[DATA_WIDTH-1]}}, s[DATA_WIDTH-1:0]};
  endfunction

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q | (tick && (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          mosi_d  = cmd_bit(CMD, 0);
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + DB'(1);
        end
      end
      S_SHIFT: begin
        div_d = div_q + DB'(1);
        if (div_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[ADC_BITS-2:0], bus.adc_miso};
        end
        if (div_q == PER_LAST) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + BB'(1);
            mosi_d = cmd_bit(CMD, 32'(bit_q) + 32'd1);
          end
        end
      end
      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d  = S_DONE;
          cs_n_d   = 1'b1;
          sample_d = to_sample(shreg_q);
          valid_d  = 1'b1;
        end else begin
          div_d = div_q + DB'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.adc_mosi     = mosi_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed/random bench for adc_sampler with an SPI ADC model.
// u0 runs defaults; u1 uses a short period to provoke overrun.
module tb_adc_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst1_n;
  logic en0;
  logic en1;

  adc_sampler_if #(.DATA_WIDTH(8)) b0 ();
  adc_sampler_if #(.DATA_WIDTH(8)) b1 ();

  adc_sampler u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(en0),
    .bus   (b0)
  );

  adc_sampler #(
    .SAMPLE_PERIOD(100)
  ) u1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .enable(en1),
    .bus   (b1)
  );

  assign b1.adc_miso = 1'b1;

  int errors = 0;
  int checks = 0;

  // Monitor state, updated on every falling clk edge.
  int          cyc = 0;
  int          n_starts = 0;
  int          last_start = 0;
  int          low_len = 0;
  int          rises = 0;
  int          last_len = 0;
  int          last_rises = 0;
  int          n_valid = 0;
  int          n_valid1 = 0;
  int          mosi_viol = 0;
  logic [15:0] mosi_w = '0;
  logic [15:0] last_mosi = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!b0.adc_cs_n && prev_cs) begin
      n_starts++;
      last_start = cyc;
      low_len = 0;
      rises = 0;
      mosi_w = '0;
    end
    if (!b0.adc_cs_n) begin
      low_len++;
      if (b0.adc_sclk && !prev_sclk) begin
        rises++;
        mosi_w = {mosi_w[14:0], b0.adc_mosi};
      end
    end
    if (b0.adc_cs_n && !prev_cs) begin
      last_len = low_len;
      last_rises = rises;
      last_mosi = mosi_w;
    end
    if (b0.adc_sclk && prev_sclk && (b0.adc_mosi !== prev_mosi))
      mosi_viol++;
    if (b0.sample_valid) n_valid++;
    if (b1.sample_valid) n_valid1++;
    prev_cs = b0.adc_cs_n;
    prev_sclk = b0.adc_sclk;
    prev_mosi = b0.adc_mosi;
  end

  // ADC model: shifts out a 16-bit frame word MSB first, next bit on SCLK fall.
  logic [15:0] adc_word = 16'hFFFF;
  logic [15:0] wsh;
  int          midx = 0;
  logic        in_frame = 1'b0;

  always @(negedge b0.adc_cs_n or negedge b0.adc_sclk
           or posedge b0.adc_cs_n) begin
    if (b0.adc_cs_n === 1'b1) begin
      in_frame = 1'b0;
    end else if (b0.adc_cs_n === 1'b0) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        midx = 0;
      end else begin
        midx++;
      end
      wsh = adc_word << midx;
      b0.adc_miso = (midx < 16) ? wsh[15] : 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget);
    int n0;
    int k;
    n0 = n_starts;
    k = 0;
    while (n_starts == n0 && k < budget) begin
      step();
      k++;
    end
    check("start_seen", n_starts - n0, 1);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!b0.sample_valid && k < budget) begin
      step();
      k++;
    end
    check("valid_seen", {31'd0, b0.sample_valid}, 1);
  endtask

  // Reference: (code - 512) / 4 rounded toward minus infinity.
  function automatic logic [15:0] model(input int code);
    int v;
    int q;
    v = code - 512;
    q = (v >= 0) ? v / 4 : -((-v + 3) / 4);
    return 16'(q);
  endfunction

  initial begin
    int r;
    int prev_start;
    int code;
    int s6;
    int n0s;
    int s7;
    int nv0;
    int r2;
    int k;

    rst_n = 1'b0;
    rst1_n = 1'b0;
    en0 = 1'b0;
    en1 = 1'b1;
    adc_word = 16'hFFFF;
    wait_cyc(3);
    check("rst_cs_n", {31'd0, b0.adc_cs_n}, 1);
    check("rst_sclk", {31'd0, b0.adc_sclk}, 0);
    check("rst_mosi", {31'd0, b0.adc_mosi}, 0);
    check("rst_sample", {16'd0, b0.sample}, 0);
    check("rst_valid", {31'd0, b0.sample_valid}, 0);
    check("rst_overrun", {31'd0, b0.overrun}, 0);

    en0 = 1'b1;
    rst_n = 1'b1;
    rst1_n = 1'b1;
    r = cyc;

    wait_cyc(150);
    check("u1_in_frame", {31'd0, b1.adc_cs_n}, 0);
    wait_cyc(49);
    check("u1_ovr_before_tick", {31'd0, b1.overrun}, 0);
    step();
    check("u1_ovr_at_tick", {31'd0, b1.overrun}, 1);

    wait_start(1000);
    check("first_start", last_start - r, 1000);
    prev_start = last_start;

    code = 10'h3FF;
    for (int f = 0; f < 6; f++) begin
      wait_valid(300);
      check("sample", {16'd0, b0.sample}, {16'd0, model(code)});
      step();
      check("valid_pulse", {31'd0, b0.sample_valid}, 0);
      check("cs_low_len", last_len, 136);
      check("sclk_rises", last_rises, 16);
      check("mosi_bits", {16'd0, last_mosi}, 32'h0000_D000);
      check("no_overrun", {31'd0, b0.overrun}, 0);
      if (f == 0) code = 10'h000;
      else if (f == 1) code = 10'h200;
      else code = int'($urandom_range(0, 1023));
      adc_word = {6'($urandom_range(0, 63)), 10'(code)};
      wait_start(1000);
      check("start_spacing", last_start - prev_start, 1000);
      prev_start = last_start;
    end

    s6 = last_start;
    wait_cyc(40);
    en0 = 1'b0;
    n0s = n_starts;
    wait_valid(300);
    check("sample_after_disable", {16'd0, b0.sample},
          {16'd0, model(code)});
    while (cyc < s6 + 2999) step();
    check("no_start_disabled", n_starts, n0s);
    en0 = 1'b1;
    step();
    check("start_on_enable_tick", n_starts, n0s + 1);
    check("restart_time", last_start - s6, 3000);

    s7 = last_start;
    code = int'($urandom_range(0, 1023));
    while (cyc < s7 + 50) step();
    nv0 = n_valid;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", {31'd0, b0.adc_cs_n}, 1);
    check("abort_sclk", {31'd0, b0.adc_sclk}, 0);
    check("abort_sample", {16'd0, b0.sample}, 0);
    check("abort_overrun", {31'd0, b0.overrun}, 0);
    wait_cyc(2);
    adc_word = {6'($urandom_range(0, 63)), 10'(code)};
    rst_n = 1'b1;
    r2 = cyc;
    k = 0;
    while (n_starts == n0s + 1 && k < 1100) begin
      step();
      k++;
    end
    check("post_reset_start", last_start - r2, 1000);
    check("no_aborted_sample", n_valid, nv0);
    wait_valid(300);
    check("post_reset_sample", {16'd0, b0.sample},
          {16'd0, model(code)});

    check("mosi_stable_high", mosi_viol, 0);
    check("u1_overrun_sticky", {31'd0, b1.overrun}, 1);
    check("u1_sample", {16'd0, b1.sample}, 32'h0000_007F);
    check("u1_delivers", {31'd0, n_valid1 > 20}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
